// File: rtl/vc_arbiter_pkg.sv
// vc_arbiter_pkg
// Shared defaults and types for the virtual-channel arbiter slice.
//   DATA_WIDTH_DEF : width of every data word
//   DEST_BIT_DEF   : word bit that selects destination D0 (0) or D1 (1)
//   VC0_BURST_DEF  : max consecutive VC0 pops while VC1 is waiting
//   vc_src_t       : which VC a popped word came from
//   streak_width() : bits needed to count 0..burst inclusive
package vc_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int DEST_BIT_DEF   = 4;
  localparam int VC0_BURST_DEF  = 4;

  typedef enum logic {
    SRC_VC0 = 1'b0,
    SRC_VC1 = 1'b1
  } vc_src_t;

  // The streak counter must be able to hold the burst value itself,
  // because saturation at exactly that value is what hands the grant to VC1.
  function automatic int streak_width(input int burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/vc_dest_demux.sv
// vc_dest_demux
// Two-stage capture/push pipeline between the VC FIFOs and the destination
// FIFOs. Stage 1 remembers that a pop happened and from which VC; one cycle
// later the VC read data is valid, is steered by its destination bit and is
// registered onto the matching push strobe and data bus.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   pop_vc0, pop_vc1   : pop strobes issued this cycle by the arbiter
//   data_vc0, data_vc1 : VC FIFO read data (valid the cycle after a pop)
//   push_d0, push_d1   : single-cycle write strobes to D0 / D1
//   data_d0, data_d1   : write data to D0 / D1, held while not pushing
//   busy               : a popped word has not yet been pushed
module vc_dest_demux
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_BIT   = DEST_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pop_vc0,
  input  logic                  pop_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_d0,
  output logic [DATA_WIDTH-1:0] data_d1,
  output logic                  busy
);

  logic                  s1_valid;
  vc_src_t               s1_src;
  logic [DATA_WIDTH-1:0] word;
  logic                  to_d1;

  // The VC FIFO presents the popped word one cycle after the strobe, so the
  // source recorded at the pop edge picks which read bus to look at now.
  assign word  = (s1_src == SRC_VC1) ? data_vc1 : data_vc0;
  assign to_d1 = word[DEST_BIT];

  // Words already in either stage finish even during a stall; only reset
  // discards them. Data buses update only on their own push so they hold
  // the last delivered word otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_src   <= SRC_VC0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_d0  <= '0;
      data_d1  <= '0;
    end else begin
      s1_valid <= pop_vc0 | pop_vc1;
      s1_src   <= pop_vc1 ? SRC_VC1 : SRC_VC0;
      push_d0  <= s1_valid & ~to_d1;
      push_d1  <= s1_valid & to_d1;
      if (s1_valid && !to_d1) begin
        data_d0 <= word;
      end
      if (s1_valid && to_d1) begin
        data_d1 <= word;
      end
    end
  end

  assign busy = s1_valid | push_d0 | push_d1;

endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter
// Arbitrates two virtual-channel FIFOs (VC0 preferred) into two destination
// FIFOs. VC0 wins unless it has already taken VC0_BURST pops in a row while
// VC1 was waiting, in which case VC1 gets one pop. Any almost-full
// destination stalls all new pops; words already popped still complete.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   empty_fifo_VC0/VC1             : VC FIFO empty flags
//   data_out_VC0/VC1               : VC FIFO read data
//   almost_full_D0/D1              : destination back-pressure
//   pop_VC0_fifo/pop_VC1_fifo      : read strobes (combinational)
//   push_D0/push_D1                : destination write strobes
//   data_out_D0/data_out_D1        : destination write data
//   idle_out                       : nothing in flight and both VCs empty
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_BIT   = DEST_BIT_DEF,
  parameter int VC0_BURST  = VC0_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [DATA_WIDTH-1:0] data_out_VC0,
  input  logic [DATA_WIDTH-1:0] data_out_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [DATA_WIDTH-1:0] data_out_D0,
  output logic [DATA_WIDTH-1:0] data_out_D1,
  output logic                  idle_out
);

  localparam int              SW        = streak_width(VC0_BURST);
  localparam logic [SW-1:0]   BURST_MAX = SW'(VC0_BURST);

  logic [SW-1:0] streak;
  logic          stall;
  logic          grant_vc0;
  logic          grant_vc1;
  logic          busy;

  // Grants are combinational so a pop can issue in the very first cycle
  // after reset; reset itself masks them. VC1 is only considered when VC0
  // did not win, which keeps the two strobes mutually exclusive.
  assign stall     = almost_full_D0 | almost_full_D1;
  assign grant_vc0 = ~reset & ~stall & ~empty_fifo_VC0 &
                     (empty_fifo_VC1 | (streak < BURST_MAX));
  assign grant_vc1 = ~reset & ~stall & ~grant_vc0 & ~empty_fifo_VC1;

  assign pop_VC0_fifo = grant_vc0;
  assign pop_VC1_fifo = grant_vc1;

  // The streak only measures how long VC1 has been kept waiting, so it is
  // meaningless (and cleared) whenever VC1 has nothing to send.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (empty_fifo_VC1 || grant_vc1) begin
      streak <= '0;
    end else if (grant_vc0 && (streak < BURST_MAX)) begin
      streak <= streak + SW'(1);
    end
  end

  vc_dest_demux #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_BIT   (DEST_BIT)
  ) u_demux (
    .clk      (clk),
    .reset    (reset),
    .pop_vc0  (grant_vc0),
    .pop_vc1  (grant_vc1),
    .data_vc0 (data_out_VC0),
    .data_vc1 (data_out_VC1),
    .push_d0  (push_D0),
    .push_d1  (push_D1),
    .data_d0  (data_out_D0),
    .data_d1  (data_out_D1),
    .busy     (busy)
  );

  // Reset forces idle high even if the VC FIFOs still hold words.
  assign idle_out = reset | (~busy & empty_fifo_VC0 & empty_fifo_VC1);

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter
// Drives vc_arbiter with directed scenarios. The bench owns behavioural
// models of both VC FIFOs (queues) and a transaction-level model of the
// arbiter: which VC should be popped, and which word must reach which
// destination two cycles later. A compare process checks every cycle;
// the directed scenarios additionally check hand-computed traces.
module tb_vc_arbiter;

  localparam int DW    = 6;
  localparam int DB    = 4;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty_fifo_VC0, empty_fifo_VC1;
  logic [DW-1:0] data_out_VC0, data_out_VC1;
  logic          almost_full_D0, almost_full_D1;
  logic          pop_VC0_fifo, pop_VC1_fifo;
  logic          push_D0, push_D1;
  logic [DW-1:0] data_out_D0, data_out_D1;
  logic          idle_out;

  vc_arbiter #(
    .DATA_WIDTH (DW),
    .DEST_BIT   (DB),
    .VC0_BURST  (BURST)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .empty_fifo_VC0 (empty_fifo_VC0),
    .empty_fifo_VC1 (empty_fifo_VC1),
    .data_out_VC0   (data_out_VC0),
    .data_out_VC1   (data_out_VC1),
    .almost_full_D0 (almost_full_D0),
    .almost_full_D1 (almost_full_D1),
    .pop_VC0_fifo   (pop_VC0_fifo),
    .pop_VC1_fifo   (pop_VC1_fifo),
    .push_D0        (push_D0),
    .push_D1        (push_D1),
    .data_out_D0    (data_out_D0),
    .data_out_D1    (data_out_D1),
    .idle_out       (idle_out)
  );

  always #5 clk = ~clk;

  // Contents of the two VC FIFOs as the bench sees them.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // A popped word together with the cycle in which it must be pushed.
  typedef struct {
    int            due;
    logic [DW-1:0] word;
  } flight_t;

  flight_t       pending[$];
  int            cyc = 0;
  int            vc0_run = 0;
  logic [DW-1:0] last_d0 = '0;
  logic [DW-1:0] last_d1 = '0;
  int            total_checks = 0;
  int            bad_checks = 0;

  // Per-cycle traces recorded by the directed scenarios.
  logic          tr_pop0[$], tr_pop1[$], tr_push0[$], tr_push1[$], tr_idle[$];
  logic [DW-1:0] tr_d0[$], tr_d1[$];

  // One comparison: counts it, and reports a FAIL line if it mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Empty flags always mirror the bench's FIFO contents.
  task automatic refresh_empty();
    empty_fifo_VC0 = (q0.size() == 0);
    empty_fifo_VC1 = (q1.size() == 0);
  endtask

  // Loads one word into a VC FIFO model.
  task automatic applyStimulus(input int vc, input logic [DW-1:0] word);
    if (vc == 0) q0.push_back(word);
    else         q1.push_back(word);
    refresh_empty();
  endtask

  task automatic clear_trace();
    tr_pop0.delete(); tr_pop1.delete(); tr_push0.delete(); tr_push1.delete();
    tr_idle.delete(); tr_d0.delete(); tr_d1.delete();
  endtask

  // One clock cycle: record outputs mid-cycle, then after the edge let the
  // VC FIFO models answer whatever the DUT popped (data valid next cycle).
  task automatic step_cycle();
    logic p0, p1;
    @(negedge clk);
    p0 = pop_VC0_fifo;
    p1 = pop_VC1_fifo;
    tr_pop0.push_back(p0);
    tr_pop1.push_back(p1);
    tr_push0.push_back(push_D0);
    tr_push1.push_back(push_D1);
    tr_idle.push_back(idle_out);
    tr_d0.push_back(data_out_D0);
    tr_d1.push_back(data_out_D1);
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) data_out_VC0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_out_VC1 = q1.pop_front();
    refresh_empty();
  endtask

  // Packs n trace bits starting at 'first' into a vector, earliest in the MSB.
  function automatic logic [31:0] pack_bits(input logic q[$], input int first, input int n);
    logic [31:0] r = '0;
    for (int i = first; i < first + n; i++) r = {r[30:0], q[i]};
    return r;
  endfunction

  // Transaction-level model and per-cycle compare. Pop choice comes from the
  // fairness rule over the queue contents; pushes come from the list of
  // words popped two cycles earlier.
  logic    m_stall, m_want0, m_want1, m_push0, m_push1, m_flight;
  flight_t m_f;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_pop0", 32'(pop_VC0_fifo), 32'd0);
      checkOutput("rst_pop1", 32'(pop_VC1_fifo), 32'd0);
      checkOutput("rst_push0", 32'(push_D0), 32'd0);
      checkOutput("rst_push1", 32'(push_D1), 32'd0);
      checkOutput("rst_data0", 32'(data_out_D0), 32'd0);
      checkOutput("rst_data1", 32'(data_out_D1), 32'd0);
      checkOutput("rst_idle", 32'(idle_out), 32'd1);
      pending.delete();
      vc0_run = 0;
      last_d0 = '0;
      last_d1 = '0;
    end else begin
      m_stall = almost_full_D0 || almost_full_D1;
      m_want0 = !m_stall && q0.size() > 0 && (q1.size() == 0 || vc0_run < BURST);
      m_want1 = !m_stall && !m_want0 && q1.size() > 0;
      m_flight = pending.size() > 0;
      m_push0 = 1'b0;
      m_push1 = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
        m_f = pending.pop_front();
        if (m_f.word[DB]) begin
          m_push1 = 1'b1;
          last_d1 = m_f.word;
        end else begin
          m_push0 = 1'b1;
          last_d0 = m_f.word;
        end
      end
      checkOutput("pop0", 32'(pop_VC0_fifo), 32'(m_want0));
      checkOutput("pop1", 32'(pop_VC1_fifo), 32'(m_want1));
      checkOutput("push0", 32'(push_D0), 32'(m_push0));
      checkOutput("push1", 32'(push_D1), 32'(m_push1));
      checkOutput("data0", 32'(data_out_D0), 32'(last_d0));
      checkOutput("data1", 32'(data_out_D1), 32'(last_d1));
      checkOutput("idle", 32'(idle_out),
                  32'(!m_flight && q0.size() == 0 && q1.size() == 0));
      if (m_want0) pending.push_back('{cyc + 2, q0[0]});
      if (m_want1) pending.push_back('{cyc + 2, q1[0]});
      if (q1.size() == 0 || m_want1) vc0_run = 0;
      else if (m_want0 && vc0_run < BURST) vc0_run++;
    end
    cyc++;
  end

  logic [15:0] af_table = 16'b0010_0110_0000_1000;
  int          both_pops;
  int          push_total;

  initial begin
    reset          = 1'b1;
    almost_full_D0 = 1'b0;
    almost_full_D1 = 1'b0;
    data_out_VC0   = '0;
    data_out_VC1   = '0;
    refresh_empty();
    repeat (2) step_cycle();
    checkOutput("reset_state_pops", 32'({pop_VC0_fifo, pop_VC1_fifo}), 32'd0);
    checkOutput("reset_state_idle", 32'(idle_out), 32'd1);

    // Three D0 words in VC0 loaded during reset; the first pop must come in
    // the first cycle after release and pushes follow two cycles later.
    applyStimulus(0, 6'h03);
    applyStimulus(0, 6'h0A);
    applyStimulus(0, 6'h21);
    reset = 1'b0;
    clear_trace();
    repeat (7) step_cycle();
    checkOutput("vc0only_pops", pack_bits(tr_pop0, 0, 7), 32'b1110000);
    checkOutput("vc0only_push0", pack_bits(tr_push0, 0, 7), 32'b0011100);
    checkOutput("vc0only_push1", pack_bits(tr_push1, 0, 7), 32'd0);
    checkOutput("vc0only_w0", 32'(tr_d0[2]), 32'h03);
    checkOutput("vc0only_w1", 32'(tr_d0[3]), 32'h0A);
    checkOutput("vc0only_w2", 32'(tr_d0[4]), 32'h21);

    // VC1 words to different destinations on consecutive cycles.
    clear_trace();
    applyStimulus(1, 6'h10);
    applyStimulus(1, 6'h05);
    repeat (6) step_cycle();
    checkOutput("vc1_pops", pack_bits(tr_pop1, 0, 6), 32'b110000);
    checkOutput("vc1_push1", pack_bits(tr_push1, 0, 6), 32'b001000);
    checkOutput("vc1_push0", pack_bits(tr_push0, 0, 6), 32'b000100);
    checkOutput("vc1_word_d1", 32'(tr_d1[2]), 32'h10);
    checkOutput("vc1_word_d0", 32'(tr_d0[3]), 32'h05);

    // Both VCs loaded with 8 words: VC0 x4, VC1 x1, repeating.
    clear_trace();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, DW'(i));
      applyStimulus(1, DW'(6'h30 + i));
    end
    repeat (20) step_cycle();
    begin
      logic [31:0] codes = '0;
      both_pops  = 0;
      push_total = 0;
      for (int i = 0; i < 16; i++) codes = {codes[29:0], tr_pop1[i], tr_pop0[i]};
      for (int i = 0; i < 20; i++) begin
        if (tr_pop0[i] && tr_pop1[i]) both_pops++;
        if (tr_push0[i]) push_total++;
        if (tr_push1[i]) push_total++;
      end
      checkOutput("burst_pattern", codes, 32'h5595_6AAA);
      checkOutput("burst_both_pops", 32'(both_pops), 32'd0);
      checkOutput("burst_push_count", 32'(push_total), 32'd16);
    end

    // Stall on D1 the cycle after a pop: the in-flight word still lands,
    // pops resume once the stall drops.
    clear_trace();
    for (int i = 1; i <= 4; i++) applyStimulus(0, DW'(i));
    step_cycle();
    almost_full_D1 = 1'b1;
    repeat (3) step_cycle();
    almost_full_D1 = 1'b0;
    repeat (6) step_cycle();
    checkOutput("stall_pops", pack_bits(tr_pop0, 0, 10), 32'b1000111000);
    checkOutput("stall_push0", pack_bits(tr_push0, 0, 10), 32'b0010001110);

    // Mixed traffic with a D0 back-pressure pattern, checked by the model.
    for (int i = 0; i < 6; i++) applyStimulus(0, DW'(6'h0C + 3 * i));
    for (int i = 0; i < 3; i++) applyStimulus(1, DW'(6'h2B - 7 * i));
    for (int i = 0; i < 16; i++) begin
      almost_full_D0 = af_table[15 - i];
      step_cycle();
    end
    almost_full_D0 = 1'b0;
    repeat (8) step_cycle();

    // Reset with two words in flight discards them.
    for (int i = 0; i < 3; i++) applyStimulus(0, DW'(6'h01 + i));
    repeat (2) step_cycle();
    reset = 1'b1;
    q0.delete();
    refresh_empty();
    #1;
    checkOutput("midreset_outputs",
                32'({pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1}), 32'd0);
    checkOutput("midreset_data", 32'({data_out_D0, data_out_D1}), 32'd0);
    checkOutput("midreset_idle", 32'(idle_out), 32'd1);
    repeat (2) step_cycle();
    reset = 1'b0;
    clear_trace();
    repeat (5) step_cycle();
    checkOutput("postreset_push0", pack_bits(tr_push0, 0, 5), 32'd0);
    checkOutput("postreset_push1", pack_bits(tr_push1, 0, 5), 32'd0);
    checkOutput("postreset_idle", pack_bits(tr_idle, 0, 5), 32'b11111);

    // Long idle period: no pops, idle stays high.
    clear_trace();
    repeat (10) step_cycle();
    checkOutput("idle_pop0", pack_bits(tr_pop0, 0, 10), 32'd0);
    checkOutput("idle_pop1", pack_bits(tr_pop1, 0, 10), 32'd0);
    checkOutput("idle_flag", pack_bits(tr_idle, 0, 10), 32'h3FF);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6: width of every data word.
REQ-002 Parameter DEST_BIT, default 4: index of the data bit selecting destination D0 (0) or D1 (1).
REQ-003 Parameter VC0_BURST, default 4: maximum consecutive VC0 pops while VC1 is non-empty.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 empty_fifo_VC0  input  1  VC0 FIFO holds no word.
REQ-007 empty_fifo_VC1  input  1  VC1 FIFO holds no word.
REQ-008 data_out_VC0  input  DATA_WIDTH  VC0 FIFO read data.
REQ-009 data_out_VC1  input  DATA_WIDTH  VC1 FIFO read data.
REQ-010 almost_full_D0  input  1  destination FIFO D0 near full.
REQ-011 almost_full_D1  input  1  destination FIFO D1 near full.
REQ-012 pop_VC0_fifo  output  1  read strobe to VC0 FIFO.
REQ-013 pop_VC1_fifo  output  1  read strobe to VC1 FIFO.
REQ-014 push_D0  output  1  write strobe to D0 FIFO.
REQ-015 push_D1  output  1  write strobe to D1 FIFO.
REQ-016 data_out_D0  output  DATA_WIDTH  write data to D0.
REQ-017 data_out_D1  output  DATA_WIDTH  write data to D1.
REQ-018 idle_out  output  1  high when no word is in flight and both VC FIFOs are empty.

Function
REQ-019 A VC FIFO's read data SHALL be taken as valid in the cycle after its pop strobe.
REQ-020 At most one of pop_VC0_fifo and pop_VC1_fifo SHALL be high in any cycle.
REQ-021 No pop SHALL be issued while almost_full_D0 or almost_full_D1 is high (stall).
REQ-022 Pop strobes SHALL be combinational from registered state and current inputs.
REQ-023 Grant rule, no stall: VC0 non-empty and (VC1 empty or streak < VC0_BURST) -> pop VC0.
REQ-024 Otherwise, with VC1 non-empty -> pop VC1.
REQ-025 The block SHALL never pop an empty FIFO.
REQ-026 Streak counter: increments on a VC0 pop while VC1 is non-empty.
REQ-027 Streak counter: clears on a VC1 pop or whenever VC1 is empty.
REQ-028 Streak counter: saturates at VC0_BURST.
REQ-029 Pipeline: pop in cycle N -> word captured at edge ending N+1.
REQ-030 Pipeline: push_Dx high with data_out_Dx in cycle N+2; latency exactly 2 cycles.
REQ-031 The destination SHALL be data bit DEST_BIT of the popped word; only that push strobe asserts.
REQ-032 The word SHALL be forwarded unmodified.
REQ-033 Back-to-back pops SHALL sustain one push per cycle; throughput is 1 word/cycle.
REQ-034 A stall SHALL not cancel words already popped; in-flight words (max 2) complete.
REQ-035 Destination FIFOs SHALL have almost_full margin of at least 2 free entries.
REQ-036 Push strobes SHALL be single-cycle per word.
REQ-037 When push_Dx is low, data_out_Dx SHALL hold its last value.

Reset
REQ-038 While reset is high: pop_VC0_fifo=0, pop_VC1_fifo=0, push_D0=0, push_D1=0.
REQ-039 While reset is high: data_out_D0=0, data_out_D1=0, streak=0, in-flight valid flags=0, idle_out=1.
REQ-040 Reset asserted mid-operation SHALL discard in-flight words; no push follows reset release.
REQ-041 The first pop SHALL be allowed in the first cycle after reset deasserts.

Structure
REQ-042 A shared package SHALL hold DATA_WIDTH, DEST_BIT and VC0_BURST defaults.
REQ-043 The grant/streak logic SHALL be in vc_arbiter.
REQ-044 The two-stage capture/push pipeline SHALL be one sub-module, vc_dest_demux.

Verification
REQ-045 VC0 holds 3 words with dest bit 0, VC1 empty -> pop_VC0 in cycles 1-3; push_D0 in cycles 3-5; data unchanged.
REQ-046 Both VCs hold 8 words, VC0_BURST=4 -> pop pattern VC0×4, VC1×1, repeating; never both pops in one cycle.
REQ-047 Words 0x10 then 0x05 popped from VC1 -> push_D1 with 0x10, then push_D0 with 0x05 on the next cycle.
REQ-048 almost_full_D1 rises the cycle after a pop -> no new pops; the in-flight word is still pushed; pops resume the cycle after it falls.
REQ-049 Reset asserted while 2 words are in flight -> all outputs 0 immediately, no push after release, idle_out=1.
REQ-050 Both VCs empty for 10 cycles -> no pop strobes; idle_out stays 1; streak stays 0.
